irq_pend_capture8: RTL and testbench



---
 rtl/irq_pkg.sv | 19 +
 rtl/irq_prio_pick.sv | 19 +
 rtl/irq_pend_capture8.sv | 96 +++++++++
 tb/tb_irq_pend_capture8.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types for the 8-line request capture path: vector/index typedefs and the present FSM states.
package irq_pkg;

    localparam int IRQ_N     = 8;
    localparam int IRQ_IDX_W = 3;

    typedef logic [IRQ_N-1:0]     irq_vec_t;
    typedef logic [IRQ_IDX_W-1:0] irq_idx_t;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } irq_st_e;

    function automatic irq_vec_t irq_onehot(input irq_idx_t idx);
        irq_onehot = irq_vec_t'(1) << idx;
    endfunction

endpackage

// File: rtl/irq_prio_pick.sv
// Highest-set-bit select over an 8-bit vector; bit 7 wins, 0 when the vector is empty.
// Purely combinational, no latency, no flow control.
module irq_prio_pick
    import irq_pkg::*;
(
    input  irq_vec_t i_vec,
    output irq_idx_t o_idx
);

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < IRQ_N; i++) begin
            if (i_vec[i]) begin
                o_idx = irq_idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/irq_pend_capture8.sv
// Captures request events into a pending vector and presents the highest eligible index on valid/ready.
// Latency: event->pend 1 clk, ->valid 2 clk; index held until accepted, one bubble between grants.
module irq_pend_capture8
    import irq_pkg::*;
#(
    parameter int EDGE = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  irq_vec_t req_in,
    input  irq_vec_t mask,
    output irq_vec_t pend_o,
    output logic     out_valid,
    output irq_idx_t out_idx,
    input  logic     out_ready,
    output logic     lost_o,
    input  logic     lost_clr
);

    irq_vec_t r_req_q;
    irq_vec_t r_pend;
    irq_idx_t r_idx;
    logic     r_lost;
    irq_st_e  r_state;
    irq_st_e  w_state_nxt;

    irq_vec_t w_set;
    irq_vec_t w_clr;
    irq_vec_t w_elig;
    irq_idx_t w_pick;
    logic     w_accept;
    logic     w_lost_evt;

    assign w_set      = (EDGE != 0) ? (req_in & ~r_req_q) : req_in;
    assign w_accept   = (r_state == ST_PRESENT) && out_ready;
    assign w_clr      = w_accept ? irq_onehot(r_idx) : '0;
    assign w_elig     = r_pend & mask;
    // A set coinciding with the clear of the same bit re-pends it and is not a loss.
    assign w_lost_evt = (EDGE != 0) && ((w_set & r_pend & ~w_clr) != '0);

    irq_prio_pick u_pick (
        .i_vec (w_elig),
        .o_idx (w_pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_q <= '0;
            r_pend  <= '0;
            r_lost  <= 1'b0;
        end else begin
            r_req_q <= req_in;
            r_pend  <= (r_pend & ~w_clr) | w_set;
            if (w_lost_evt) begin
                r_lost <= 1'b1;
            end else if (lost_clr) begin
                r_lost <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (w_elig != '0) w_state_nxt = ST_PRESENT;
            ST_PRESENT: if (out_ready)    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    // The winner is latched only when leaving IDLE so the presented index never moves mid-handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx <= '0;
        end else if ((r_state == ST_IDLE) && (w_elig != '0)) begin
            r_idx <= w_pick;
        end
    end

    always_comb begin
        out_valid = (r_state == ST_PRESENT);
    end

    assign pend_o  = r_pend;
    assign out_idx = r_idx;
    assign lost_o  = r_lost;

endmodule

// File: tb/tb_irq_pend_capture8.sv
// Directed bench for irq_pend_capture8: edge-mode instance and level-mode instance on one clock.
module tb_irq_pend_capture8;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, out_ready, lost_clr;
    logic [7:0] req_in, mask, pend_o;
    logic       out_valid, lost_o;
    logic [2:0] out_idx;

    logic       l_rst, l_ready, l_lost_clr;
    logic [7:0] l_req, l_mask, l_pend;
    logic       l_valid, l_lost;
    logic [2:0] l_idx;

    int n_checks = 0;
    int n_fail   = 0;

    irq_pend_capture8 #(.EDGE(1)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .mask      (mask),
        .pend_o    (pend_o),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_ready (out_ready),
        .lost_o    (lost_o),
        .lost_clr  (lost_clr)
    );

    irq_pend_capture8 #(.EDGE(0)) u_lvl (
        .clk       (clk),
        .rst       (l_rst),
        .req_in    (l_req),
        .mask      (l_mask),
        .pend_o    (l_pend),
        .out_valid (l_valid),
        .out_idx   (l_idx),
        .out_ready (l_ready),
        .lost_o    (l_lost),
        .lost_clr  (l_lost_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_in = 8'hFF; mask = 8'hFF; out_ready = 1'b0; lost_clr = 1'b0;
        l_rst = 1'b1; l_req = 8'h00; l_mask = 8'hFF; l_ready = 1'b0; l_lost_clr = 1'b0;

        // Reset with all requests high, then they count as edges on the first clock after release.
        tick(3);
        chk("rst_pend",  pend_o,    8'h00);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_idx",   out_idx,   3'd0);
        chk("rst_lost",  lost_o,    1'b0);
        rst = 1'b0;
        tick(1);
        chk("post_rst_pend",  pend_o,    8'hFF);
        chk("post_rst_valid", out_valid, 1'b0);
        tick(1);
        chk("post_rst_valid2", out_valid, 1'b1);
        chk("post_rst_idx",    out_idx,   3'd7);
        chk("post_rst_lost",   lost_o,    1'b0);
        out_ready = 1'b1;
        tick(16);
        chk("drain_pend",  pend_o,    8'h00);
        chk("drain_valid", out_valid, 1'b0);
        req_in = 8'h00;
        tick(1);

        // Two simultaneous edges: 5 before 2, one bubble between.
        req_in = 8'h24;
        tick(1);
        chk("prio_pend",   pend_o,    8'h24);
        chk("prio_valid0", out_valid, 1'b0);
        tick(1);
        chk("prio_valid1", out_valid, 1'b1);
        chk("prio_idx5",   out_idx,   3'd5);
        tick(1);
        chk("prio_bubble", out_valid, 1'b0);
        chk("prio_pend2",  pend_o,    8'h04);
        tick(1);
        chk("prio_valid2", out_valid, 1'b1);
        chk("prio_idx2",   out_idx,   3'd2);
        tick(1);
        chk("prio_empty",  pend_o,    8'h00);
        req_in = 8'h00; out_ready = 1'b0;
        tick(1);

        // Stall: presented index holds through a higher arrival and its own mask drop.
        req_in = 8'h08;
        tick(2);
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_idx",   out_idx,   3'd3);
        tick(10);
        chk("stall_idx10", out_idx,   3'd3);
        req_in = 8'h48; mask = 8'hF7;
        tick(1);
        chk("stall_pend",   pend_o,    8'h48);
        chk("stall_valid2", out_valid, 1'b1);
        chk("stall_idx_hold", out_idx, 3'd3);
        out_ready = 1'b1;
        tick(1);
        chk("stall_acc_pend",  pend_o,    8'h40);
        chk("stall_acc_valid", out_valid, 1'b0);
        tick(1);
        chk("stall_next_idx",   out_idx,   3'd6);
        chk("stall_next_valid", out_valid, 1'b1);
        tick(1);
        chk("stall_done_pend", pend_o, 8'h00);
        out_ready = 1'b0; req_in = 8'h00; mask = 8'hFF;
        tick(1);

        // Loss on a pending bit, set-wins on accept, clear vs new loss priority.
        req_in = 8'h10;
        tick(2);
        chk("lost_present", out_idx, 3'd4);
        req_in = 8'h00;
        tick(1);
        chk("lost_before", lost_o, 1'b0);
        req_in = 8'h10;
        tick(1);
        chk("lost_set", lost_o, 1'b1);
        req_in = 8'h00; lost_clr = 1'b1;
        tick(1);
        chk("lost_clr", lost_o, 1'b0);
        lost_clr = 1'b0; req_in = 8'h10; out_ready = 1'b1;
        tick(1);
        chk("setwin_pend",  pend_o,    8'h10);
        chk("setwin_lost",  lost_o,    1'b0);
        chk("setwin_valid", out_valid, 1'b0);
        tick(1);
        chk("setwin_repres", out_valid, 1'b1);
        out_ready = 1'b0; req_in = 8'h00;
        tick(1);
        req_in = 8'h10; lost_clr = 1'b1;
        tick(1);
        chk("lost_clr_vs_set", lost_o, 1'b1);
        lost_clr = 1'b1; req_in = 8'h00;
        tick(1);
        chk("lost_clr2", lost_o, 1'b0);
        lost_clr = 1'b0; out_ready = 1'b1;
        tick(1);
        chk("lost_drain", pend_o, 8'h00);
        out_ready = 1'b0;

        // Masked bits pend but are not presented until unmasked.
        mask = 8'h00; req_in = 8'h02;
        tick(1);
        chk("mask_pend", pend_o, 8'h02);
        tick(3);
        chk("mask_novalid", out_valid, 1'b0);
        mask = 8'h02;
        tick(1);
        chk("mask_valid", out_valid, 1'b1);
        chk("mask_idx",   out_idx,   3'd1);

        // Level mode: held request re-pends after every accept, never lost.
        l_rst = 1'b0; l_req = 8'h01; l_ready = 1'b1;
        tick(1);
        chk("lvl_pend",   l_pend,  8'h01);
        chk("lvl_valid0", l_valid, 1'b0);
        tick(1);
        chk("lvl_valid1", l_valid, 1'b1);
        chk("lvl_idx",    l_idx,   3'd0);
        tick(1);
        chk("lvl_bubble", l_valid, 1'b0);
        chk("lvl_repend", l_pend,  8'h01);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("lvl_lost", l_lost, 1'b0);
            chk("lvl_alt",  l_valid, (i % 2 == 0) ? 1'b1 : 1'b0);
        end
        l_ready = 1'b0;
        tick(2);
        chk("lvl_present", l_valid, 1'b1);
        l_rst = 1'b1;
        tick(1);
        chk("lvl_rst_valid", l_valid, 1'b0);
        chk("lvl_rst_pend",  l_pend,  8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
